bus_read_select: RTL and testbench

Read-side counterpart of the memory-mapped write decoder: steers CPU loads to data memory or to peripheral readback registers, and returns one-cycle-latency read data with a valid strobe. Sits between the CPU load port, the synchronous DMEM read port and the VGA, seven-segment, timer and keyboard peripherals. Owns a small keyboard input FIFO that is popped by CPU reads.

---
 rtl/bus_map_pkg.sv | 23 ++
 rtl/key_fifo.sv | 134 +++++++++++++
 rtl/bus_read_select.sv | 121 ++++++++++++
 tb/tb_bus_read_select.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_map_pkg.sv
// ---------------------------------------------------------------------------
// bus_map_pkg
// Shared memory-map constants for the CPU bus. The write decoder and the
// read-side select both import this package, so the peripheral map lives in
// exactly one place.
//   ADDR_*   : 12-bit peripheral offsets (only addr[11:0] is decoded)
//   rd_sel_t : source of the load data in the return cycle
// ---------------------------------------------------------------------------
package bus_map_pkg;

  localparam logic [11:0] ADDR_VGA      = 12'h800;
  localparam logic [11:0] ADDR_SEG      = 12'h804;
  localparam logic [11:0] ADDR_KEY_DATA = 12'h808;
  localparam logic [11:0] ADDR_KEY_STAT = 12'h80C;
  localparam logic [11:0] ADDR_TIMER    = 12'h814;

  typedef enum logic [1:0] {
    SEL_DMEM = 2'd0,  // data comes straight from the DMEM read port
    SEL_REG  = 2'd1,  // data was captured into the return register
    SEL_NONE = 2'd2   // unmapped peripheral address, reads zero
  } rd_sel_t;

endpackage

// File: rtl/key_fifo.sv
// ---------------------------------------------------------------------------
// key_fifo
// Keyboard scan-code buffer popped by CPU reads of KEY_DATA.
// Build option: define KEY_FIFO_EN for a DEPTH-entry FIFO; otherwise a single
// holding register where a new code overwrites an unread one.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   push         : key_valid strobe, push_code is the new scan code
//   pop          : pop request (ignored when empty)
//   ovf_clr      : clear the sticky overflow flag (a same-cycle set wins)
//   head_code    : oldest stored code
//   empty, full  : occupancy flags
//   count        : number of stored codes, zero-extended/truncated to 4 bits
//   overflow     : sticky flag, a code was dropped or overwritten
// ---------------------------------------------------------------------------
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_code,
  input  logic       pop,
  input  logic       ovf_clr,
  output logic [7:0] head_code,
  output logic       empty,
  output logic       full,
  output logic [3:0] count,
  output logic       overflow
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          do_pop;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] count_q, count_d;

  assign do_pop   = pop && !empty;
  assign count    = 4'(count_q);
  assign overflow = ovf_q;

  // A push only loses data when the buffer is full and nothing leaves it in
  // the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (push && full && !do_pop) ovf_d = 1'b1;
  end

`ifdef KEY_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign do_push   = push && (!full || do_pop);
  assign head_code = mem_q[rd_ptr_q];

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is left out of reset; occupancy is governed entirely by
  // the pointers and count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end
`else
  logic [7:0] hold_q, hold_d;

  assign empty     = (count_q == '0);
  assign full      = !empty;
  assign head_code = hold_q;

  // Holding register: any new key replaces the stored one; the slot is
  // occupied after a push, or if it was occupied and not read.
  always_comb begin
    hold_d  = hold_q;
    count_d = count_q;
    if (push) begin
      hold_d  = push_code;
      count_d = CW'(1);
    end else if (do_pop) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
`endif

endmodule

// File: rtl/bus_read_select.sv
// ---------------------------------------------------------------------------
// bus_read_select
// Read-side bus decoder: steers CPU loads to DMEM or to peripheral readback
// registers and returns data one cycle later with a valid strobe. Owns the
// keyboard buffer (key_fifo), which is popped by KEY_DATA reads.
// Build option: KEY_FIFO_EN selects a KEY_DEPTH-entry keyboard FIFO instead
// of a single holding register.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   addr, re            : CPU load address (addr[11:0] decoded) and request
//   rdata, rvalid       : load data, valid one cycle after re; zero otherwise
//   dmem_re, dmem_rdata : DMEM read enable (combinational) and sync read data
//   vga_status, seg_value, timer_count : peripheral readback words
//   key_valid, key_code : keyboard scan-code strobe and code
// ---------------------------------------------------------------------------
module bus_read_select #(
  parameter int KEY_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        dmem_re,
  input  logic [31:0] dmem_rdata,
  input  logic [31:0] vga_status,
  input  logic [31:0] seg_value,
  input  logic [31:0] timer_count,
  input  logic        key_valid,
  input  logic [7:0]  key_code
);

  import bus_map_pkg::*;

  logic [11:0] offs;
  logic        addr_hi_unused;
  rd_sel_t     sel_q, sel_d;
  logic [31:0] data_q, data_d;
  logic        rvalid_q, rvalid_d;
  logic        key_pop, key_ovf_clr;
  logic [7:0]  key_head;
  logic        key_empty, key_full, key_ovf;
  logic [3:0]  key_count;

  assign offs           = addr[11:0];
  assign addr_hi_unused = ^addr[31:12];
  assign dmem_re        = re && !offs[11];

  key_fifo #(.DEPTH(KEY_DEPTH)) u_key_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (key_valid),
    .push_code(key_code),
    .pop      (key_pop),
    .ovf_clr  (key_ovf_clr),
    .head_code(key_head),
    .empty    (key_empty),
    .full     (key_full),
    .count    (key_count),
    .overflow (key_ovf)
  );

  // Peripheral words are captured at the request edge; for DMEM only the
  // select is registered because the memory itself supplies the data later.
  always_comb begin
    sel_d       = sel_q;
    data_d      = data_q;
    rvalid_d    = re;
    key_pop     = 1'b0;
    key_ovf_clr = 1'b0;
    if (re) begin
      data_d = '0;
      if (!offs[11]) begin
        sel_d = SEL_DMEM;
      end else begin
        sel_d = SEL_REG;
        case (offs)
          ADDR_VGA:      data_d = vga_status;
          ADDR_SEG:      data_d = seg_value;
          ADDR_TIMER:    data_d = timer_count;
          ADDR_KEY_DATA: begin
            key_pop = 1'b1;
            if (!key_empty) data_d = {23'h0, 1'b1, key_head};
          end
          ADDR_KEY_STAT: begin
            key_ovf_clr = 1'b1;
            data_d      = {key_ovf, 27'h0, key_count};
          end
          default:       sel_d = SEL_NONE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= SEL_NONE;
      data_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      data_q   <= data_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid = rvalid_q;

  always_comb begin
    rdata = '0;
    if (rvalid_q) begin
      case (sel_q)
        SEL_DMEM: rdata = dmem_rdata;
        SEL_REG:  rdata = data_q;
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_read_select.sv
// ---------------------------------------------------------------------------
// tb_bus_read_select
// Self-checking bench for bus_read_select. A queue-based keyboard model and a
// pending-response record predict rvalid/rdata/dmem_re every cycle; directed
// sequences pin the model with literal expectations, then random traffic runs.
// Honours KEY_FIFO_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_bus_read_select;

  localparam int KEY_DEPTH = 4;
`ifdef KEY_FIFO_EN
  localparam int CAP = KEY_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        dmem_re;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] vga_status = '0;
  logic [31:0] seg_value = '0;
  logic [31:0] timer_count = '0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = '0;

  always #5 clk = ~clk;

  bus_read_select #(.KEY_DEPTH(KEY_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .re         (re),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .dmem_re    (dmem_re),
    .dmem_rdata (dmem_rdata),
    .vga_status (vga_status),
    .seg_value  (seg_value),
    .timer_count(timer_count),
    .key_valid  (key_valid),
    .key_code   (key_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  kq[$];
  bit          ovf = 1'b0;
  bit          pend_valid = 1'b0;
  bit          pend_dmem = 1'b0;
  logic [31:0] pend_data = '0;
  bit          exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  bit          dmem_fix_en = 1'b0;
  logic [31:0] dmem_fix = '0;

  // Evaluate the request currently on the inputs against the model and apply
  // the keyboard side effects of the coming edge.
  task automatic model_issue();
    logic [11:0] a;
    bit do_pop, do_clr;
    a = addr[11:0];
    pend_valid = re;
    pend_dmem  = 1'b0;
    pend_data  = '0;
    do_pop = 1'b0;
    do_clr = 1'b0;
    if (re) begin
      if (!a[11]) pend_dmem = 1'b1;
      else begin
        case (a)
          12'h800: pend_data = vga_status;
          12'h804: pend_data = seg_value;
          12'h814: pend_data = timer_count;
          12'h808: if (kq.size() > 0) begin
            pend_data = {23'h0, 1'b1, kq[0]};
            do_pop = 1'b1;
          end
          12'h80C: begin
            pend_data = {ovf, 27'h0, 4'(kq.size())};
            do_clr = 1'b1;
          end
          default: pend_data = '0;
        endcase
      end
    end
    if (do_pop) void'(kq.pop_front());
    if (do_clr) ovf = 1'b0;
    if (key_valid) begin
      if (kq.size() < CAP) kq.push_back(key_code);
      else begin
        ovf = 1'b1;
`ifndef KEY_FIFO_EN
        kq[0] = key_code;
`endif
      end
    end
  endtask

  // Called at posedge+1: drive one request, cross the edge, set up the
  // return-cycle expectation. Returns at posedge+1 of the return cycle.
  task automatic cycle(input bit r, input logic [31:0] a, input bit kv, input logic [7:0] kc);
    re = r;
    addr = a;
    key_valid = kv;
    key_code = kc;
    model_issue();
    @(posedge clk);
    #1;
    dmem_rdata = dmem_fix_en ? dmem_fix : $urandom();
    exp_valid = pend_valid;
    exp_data  = !pend_valid ? 32'h0 : (pend_dmem ? dmem_rdata : pend_data);
    re = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic lit(input string name, input bit v, input logic [31:0] d);
    #1;
    check({name, "_rvalid"}, {31'h0, rvalid}, {31'h0, v});
    check({name, "_rdata"}, rdata, d);
  endtask

  // The single compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    check("rvalid", {31'h0, rvalid}, {31'h0, exp_valid});
    check("rdata", rdata, exp_data);
    check("dmem_re", {31'h0, dmem_re}, {31'h0, re && !addr[11]});
  end

  initial begin
    logic [31:0] ra;
    int sel;

    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Timer read, then idle cycle
    timer_count = 32'h0000_1234;
    cycle(1, 32'h0000_0814, 0, 8'h00);
    lit("timer", 1'b1, 32'h0000_1234);
    cycle(0, 32'h0, 0, 8'h00);
    lit("idle", 1'b0, 32'h0);

    // DMEM load
    dmem_fix_en = 1'b1;
    dmem_fix = 32'hDEAD_BEEF;
    re = 1'b1;
    addr = 32'h0000_0010;
    #1;
    check("dmem_re_issue", {31'h0, dmem_re}, 32'h1);
    cycle(1, 32'h0000_0010, 0, 8'h00);
    lit("dmem", 1'b1, 32'hDEAD_BEEF);
    dmem_fix_en = 1'b0;

    // Two pushes, three KEY_DATA reads, then KEY_STAT to clear any overflow
    cycle(0, 32'h0, 1, 8'h1C);
    cycle(0, 32'h0, 1, 8'h32);
    cycle(1, 32'h808, 0, 8'h00);
`ifdef KEY_FIFO_EN
    lit("key_rd1", 1'b1, 32'h0000_011C);
    cycle(1, 32'h808, 0, 8'h00);
    lit("key_rd2", 1'b1, 32'h0000_0132);
    cycle(1, 32'h808, 0, 8'h00);
    lit("key_rd3", 1'b1, 32'h0);
    cycle(1, 32'h80C, 0, 8'h00);
    lit("key_stat0", 1'b1, 32'h0);
`else
    lit("key_rd1", 1'b1, 32'h0000_0132);
    cycle(1, 32'h808, 0, 8'h00);
    lit("key_rd2", 1'b1, 32'h0);
    cycle(1, 32'h808, 0, 8'h00);
    lit("key_rd3", 1'b1, 32'h0);
    cycle(1, 32'h80C, 0, 8'h00);
    lit("key_stat0", 1'b1, 32'h8000_0000);
`endif

    // Five pushes: overflow, then overflow cleared by the first status read
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 1, 8'(8'h40 + i));
    cycle(1, 32'h80C, 0, 8'h00);
`ifdef KEY_FIFO_EN
    lit("stat_ovf", 1'b1, 32'h8000_0004);
    cycle(1, 32'h80C, 0, 8'h00);
    lit("stat_clr", 1'b1, 32'h0000_0004);
`else
    lit("stat_ovf", 1'b1, 32'h8000_0001);
    cycle(1, 32'h80C, 0, 8'h00);
    lit("stat_clr", 1'b1, 32'h0000_0001);
`endif
    for (int i = 0; i < 5; i++) cycle(1, 32'h808, 0, 8'h00);

    // Push and pop in the same cycle with codes stored
    cycle(0, 32'h0, 1, 8'hA1);
    cycle(0, 32'h0, 1, 8'hA2);
    cycle(1, 32'h808, 1, 8'hA3);
`ifdef KEY_FIFO_EN
    lit("pushpop", 1'b1, 32'h0000_01A1);
    cycle(1, 32'h80C, 0, 8'h00);
    lit("pushpop_stat", 1'b1, 32'h0000_0002);
`else
    lit("pushpop", 1'b1, 32'h0000_01A2);
    cycle(1, 32'h80C, 0, 8'h00);
    lit("pushpop_stat", 1'b1, 32'h8000_0001);
`endif
    for (int i = 0; i < 5; i++) cycle(1, 32'h808, 0, 8'h00);

    // Empty plus simultaneous push and pop
    cycle(1, 32'h808, 1, 8'h55);
    lit("empty_pushpop", 1'b1, 32'h0);
    cycle(1, 32'h808, 0, 8'h00);
    lit("empty_pushpop_next", 1'b1, 32'h0000_0155);

    // Back-to-back alternating reads
    seg_value = 32'd7;
    cycle(1, 32'h804, 0, 8'h00);
    lit("alt0", 1'b1, 32'd7);
    cycle(1, 32'h900, 0, 8'h00);
    lit("alt1", 1'b1, 32'd0);
    cycle(1, 32'h804, 0, 8'h00);
    lit("alt2", 1'b1, 32'd7);
    cycle(1, 32'h900, 0, 8'h00);
    lit("alt3", 1'b1, 32'd0);

    // Reset asserted while a load is returning and keys are buffered
    cycle(0, 32'h0, 1, 8'h77);
    cycle(1, 32'h808, 0, 8'h00);
    rst_n = 1'b0;
    kq.delete();
    ovf = 1'b0;
    exp_valid = 1'b0;
    exp_data = '0;
    #1;
    check("rst_drop_rvalid", {31'h0, rvalid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 32'h80C, 0, 8'h00);
    lit("rst_stat", 1'b1, 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      vga_status  = $urandom();
      seg_value   = $urandom();
      timer_count = $urandom();
      sel = int'($urandom_range(0, 7));
      ra = $urandom();
      case (sel)
        0: ra[11] = 1'b0;
        1: ra[11:0] = 12'h800;
        2: ra[11:0] = 12'h804;
        3: ra[11:0] = 12'h808;
        4: ra[11:0] = 12'h80C;
        5: ra[11:0] = 12'h814;
        6: ra[11:0] = 12'h810;
        default: ra[11] = 1'b1;
      endcase
      cycle($urandom_range(0, 3) != 0, ra, $urandom_range(0, 2) == 0, 8'($urandom()));
    end
    cycle(0, 32'h0, 0, 8'h00);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
